// File: rtl/pwm_duty_ctrl_if.sv
// pwm_duty_ctrl_if: control/status bundle between the button front panel and pwm_duty_ctrl
//   master: drives ena, btn_inc, btn_dec; observes duty, duty_upd, at_max, at_min
//   slave : the duty controller
interface pwm_duty_ctrl_if;
  logic       ena;
  logic       btn_inc;
  logic       btn_dec;
  logic [3:0] duty;
  logic       duty_upd;
  logic       at_max;
  logic       at_min;
  modport master (output ena, btn_inc, btn_dec, input duty, duty_upd, at_max, at_min);
  modport slave  (input ena, btn_inc, btn_dec, output duty, duty_upd, at_max, at_min);
endinterface

// File: rtl/pwm_duty_ctrl.sv
// pwm_duty_ctrl: debounced inc/dec buttons stepping a saturating 4-bit PWM duty command
//   clk, rst_n    : clock, synchronous active-low reset
//   bus.ena       : block enable (prescaler and button FSMs hold while low)
//   bus.btn_inc/dec: raw asynchronous buttons
//   bus.duty      : duty command, 0..DUTY_MAX
//   bus.duty_upd  : one-cycle pulse in the first cycle a new duty is visible
//   bus.at_max/min: decodes of duty==DUTY_MAX / duty==0
//   Macro PWM_DUTY_AUTO_REPEAT_EN adds auto-repeat while a key stays held.
module pwm_duty_ctrl #(
  parameter int TICK_DIV     = 4,
  parameter int DEB_TICKS    = 3,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 2,
  parameter int DUTY_MAX     = 10,
  parameter int DUTY_INIT    = 5
) (
  input logic            clk,
  input logic            rst_n,
  pwm_duty_ctrl_if.slave bus
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = $clog2(DEB_TICKS + 1);
  localparam logic [2:0] IDLE = 3'd0, ARM = 3'd1, HELD = 3'd2, REL = 3'd4;
`ifdef PWM_DUTY_AUTO_REPEAT_EN
  localparam logic [2:0] REPEAT = 3'd3;
  localparam int RW = $clog2((REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE) + 1);
`endif
  // bit 0 = inc, bit 1 = dec
  logic [1:0] s1_q, s2_q;
  logic [1:0] step;
  logic [PW-1:0] pre_q;
  logic tick;
  logic [3:0] duty_q, duty_d;
  logic upd_q;
  logic inc_ok, dec_ok;
  always_ff @(posedge clk)
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= {bus.btn_dec, bus.btn_inc};
      s2_q <= s1_q;
    end
  assign tick = bus.ena && pre_q == PW'(TICK_DIV - 1);
  always_ff @(posedge clk)
    if (!rst_n) pre_q <= '0;
    else if (bus.ena) pre_q <= tick ? '0 : pre_q + 1'b1;
  for (genvar i = 0; i < 2; i++) begin : g_btn
    logic [2:0] st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic done, stp;
`ifdef PWM_DUTY_AUTO_REPEAT_EN
    logic [RW-1:0] rep_q, rep_d;
`endif
    // cnt_q holds agreeing ticks already seen; it is 0 in IDLE and HELD so one compare serves both debounces
    assign done = cnt_q == CW'(DEB_TICKS - 1);
    assign step[i] = stp;
    always_comb begin
      st_d = st_q;
      cnt_d = cnt_q;
      stp = 1'b0;
`ifdef PWM_DUTY_AUTO_REPEAT_EN
      rep_d = rep_q;
`endif
      if (tick)
        case (st_q)
          IDLE, ARM: begin
            st_d = !s2_q[i] ? IDLE : done ? HELD : ARM;
            cnt_d = (!s2_q[i] || done) ? '0 : cnt_q + 1'b1;
            stp = s2_q[i] && done;
`ifdef PWM_DUTY_AUTO_REPEAT_EN
            rep_d = '0;
`endif
          end
          HELD, REL: begin
            if (!s2_q[i]) begin
              st_d = done ? IDLE : REL;
              cnt_d = done ? '0 : cnt_q + 1'b1;
            end else if (st_q == REL) begin
              st_d = HELD;
              cnt_d = '0;
`ifdef PWM_DUTY_AUTO_REPEAT_EN
              rep_d = '0;
            end else if (rep_q == RW'(REPEAT_DELAY - 1)) begin
              st_d = REPEAT;
              rep_d = '0;
            end else begin
              rep_d = rep_q + 1'b1;
`endif
            end
          end
`ifdef PWM_DUTY_AUTO_REPEAT_EN
          REPEAT: begin
            if (!s2_q[i]) begin
              st_d = done ? IDLE : REL;
              cnt_d = done ? '0 : cnt_q + 1'b1;
            end else begin
              stp = rep_q == RW'(REPEAT_RATE - 1);
              rep_d = stp ? '0 : rep_q + 1'b1;
            end
          end
`endif
          default: begin
            st_d = IDLE;
            cnt_d = '0;
          end
        endcase
    end
    always_ff @(posedge clk)
      if (!rst_n) begin
        st_q <= IDLE;
        cnt_q <= '0;
      end else begin
        st_q <= st_d;
        cnt_q <= cnt_d;
      end
`ifdef PWM_DUTY_AUTO_REPEAT_EN
    always_ff @(posedge clk) rep_q <= !rst_n ? '0 : rep_d;
`endif
  end
  // simultaneous steps cancel; saturated steps are dropped without a pulse
  assign inc_ok = step[0] && !step[1] && duty_q < 4'(DUTY_MAX);
  assign dec_ok = step[1] && !step[0] && duty_q != 4'd0;
  assign duty_d = inc_ok ? duty_q + 4'd1 : dec_ok ? duty_q - 4'd1 : duty_q;
  always_ff @(posedge clk)
    if (!rst_n) begin
      duty_q <= 4'(DUTY_INIT);
      upd_q <= 1'b0;
    end else begin
      duty_q <= duty_d;
      upd_q <= inc_ok || dec_ok;
    end
  assign bus.duty = duty_q;
  assign bus.duty_upd = upd_q;
  assign bus.at_max = duty_q == 4'(DUTY_MAX);
  assign bus.at_min = duty_q == 4'd0;
endmodule
